// File: rtl/arbitro_memoria.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_memoria
// Purpose  : Shares the single-port memoria between the instruction-fetch
//            port and the data load/store port. One transaction at a time,
//            each strobe held LAT_MEM cycles, one-cycle ack to the winner.
// Option   : ROUND_ROBIN_EN - alternate grants on contention instead of the
//            default fixed data-port priority.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_memoria #(
  parameter int LARGURA_END  = 32,
  parameter int LARGURA_DADO = 32,
  parameter int LAT_MEM      = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    inst_req,
  input  logic [LARGURA_END-1:0]  inst_end,
  output logic                    inst_ack,
  output logic [LARGURA_DADO-1:0] inst_dado,
  input  logic                    dado_req,
  input  logic                    dado_we,
  input  logic [LARGURA_END-1:0]  dado_end,
  input  logic [LARGURA_DADO-1:0] dado_wdata,
  output logic                    dado_ack,
  output logic [LARGURA_DADO-1:0] dado_rdata,
  output logic [LARGURA_END-1:0]  endereco,
  output logic [LARGURA_DADO-1:0] dado_escrita,
  output logic                    uc_escrita_mem,
  output logic                    uc_leitura_mem,
  input  logic [LARGURA_DADO-1:0] instrucao,
  output logic                    ocupado
);

  localparam int LARG_CNT = (LAT_MEM > 1) ? $clog2(LAT_MEM) : 1;
  localparam logic [LARG_CNT-1:0] CNT_INICIAL = LARG_CNT'(LAT_MEM - 1);
  localparam logic [LARG_CNT-1:0] CNT_UM      = LARG_CNT'(1);
  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DADO = 1'b1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t                 estado_q, estado_d;
  logic [LARG_CNT-1:0]     cnt_q, cnt_d;
  logic [LARGURA_END-1:0]  end_q, end_d;
  logic [LARGURA_DADO-1:0] wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    grant_q, grant_d;
  logic                    esc_q, esc_d;
  logic                    leit_q, leit_d;
  logic                    inst_ack_q, inst_ack_d;
  logic                    dado_ack_q, dado_ack_d;
  logic [LARGURA_DADO-1:0] inst_dado_q, inst_dado_d;
  logic [LARGURA_DADO-1:0] dado_rdata_q, dado_rdata_d;
  logic                    ocupado_q, ocupado_d;
`ifdef ROUND_ROBIN_EN
  logic                    ultimo_q, ultimo_d;
`endif

  logic w_grant;
  logic w_we;

  // Pick which port would win if a grant happened this cycle
  always_comb begin
    w_grant = GNT_INST;
`ifdef ROUND_ROBIN_EN
    if (inst_req && dado_req) begin
      w_grant = ~ultimo_q;
    end else if (dado_req) begin
      w_grant = GNT_DADO;
    end
`else
    if (dado_req) begin
      w_grant = GNT_DADO;
    end
`endif
    // A fetch is always a read
    w_we = (w_grant == GNT_DADO) ? dado_we : 1'b0;
  end

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    end_d        = end_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    grant_d      = grant_q;
    esc_d        = esc_q;
    leit_d       = leit_q;
    inst_ack_d   = 1'b0;
    dado_ack_d   = 1'b0;
    inst_dado_d  = inst_dado_q;
    dado_rdata_d = dado_rdata_q;
    ocupado_d    = ocupado_q;
`ifdef ROUND_ROBIN_EN
    ultimo_d     = ultimo_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (inst_req || dado_req) begin
          grant_d   = w_grant;
          we_d      = w_we;
          end_d     = (w_grant == GNT_DADO) ? dado_end : inst_end;
          wdata_d   = (w_grant == GNT_DADO) ? dado_wdata : '0;
          esc_d     = w_we;
          leit_d    = ~w_we;
          cnt_d     = CNT_INICIAL;
          ocupado_d = 1'b1;
          estado_d  = ACESSO;
`ifdef ROUND_ROBIN_EN
          ultimo_d  = w_grant;
`endif
        end
      end
      ACESSO: begin
        if (cnt_q == '0) begin
          // Memory has had LAT_MEM cycles: sample the word and release strobes
          if (!we_q) begin
            if (grant_q == GNT_DADO) begin
              dado_rdata_d = instrucao;
            end else begin
              inst_dado_d = instrucao;
            end
          end
          esc_d      = 1'b0;
          leit_d     = 1'b0;
          inst_ack_d = (grant_q == GNT_INST);
          dado_ack_d = (grant_q == GNT_DADO);
          estado_d   = RESPOSTA;
        end else begin
          cnt_d = cnt_q - CNT_UM;
        end
      end
      RESPOSTA: begin
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q     <= OCIOSO;
      cnt_q        <= '0;
      end_q        <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      grant_q      <= GNT_INST;
      esc_q        <= 1'b0;
      leit_q       <= 1'b0;
      inst_ack_q   <= 1'b0;
      dado_ack_q   <= 1'b0;
      inst_dado_q  <= '0;
      dado_rdata_q <= '0;
      ocupado_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ultimo_q     <= GNT_DADO;
`endif
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      end_q        <= end_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      esc_q        <= esc_d;
      leit_q       <= leit_d;
      inst_ack_q   <= inst_ack_d;
      dado_ack_q   <= dado_ack_d;
      inst_dado_q  <= inst_dado_d;
      dado_rdata_q <= dado_rdata_d;
      ocupado_q    <= ocupado_d;
`ifdef ROUND_ROBIN_EN
      ultimo_q     <= ultimo_d;
`endif
    end
  end

  assign endereco       = end_q;
  assign dado_escrita   = wdata_q;
  assign uc_escrita_mem = esc_q;
  assign uc_leitura_mem = leit_q;
  assign inst_ack       = inst_ack_q;
  assign dado_ack       = dado_ack_q;
  assign inst_dado      = inst_dado_q;
  assign dado_rdata     = dado_rdata_q;
  assign ocupado        = ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_memoria
// Purpose  : Scoreboard bench for arbitro_memoria (LAT_MEM=2). Expected
//            memory accesses and acks are queued in service order; a monitor
//            pops and compares whenever the DUT starts an access or acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_memoria;

  localparam int LAT_MEM = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inst_req;
  logic [31:0] inst_end;
  logic        inst_ack;
  logic [31:0] inst_dado;
  logic        dado_req;
  logic        dado_we;
  logic [31:0] dado_end;
  logic [31:0] dado_wdata;
  logic        dado_ack;
  logic [31:0] dado_rdata;
  logic [31:0] endereco;
  logic [31:0] dado_escrita;
  logic        uc_escrita_mem;
  logic        uc_leitura_mem;
  logic [31:0] instrucao;
  logic        ocupado;

  arbitro_memoria #(
    .LARGURA_END (32),
    .LARGURA_DADO(32),
    .LAT_MEM     (LAT_MEM)
  ) u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .inst_req      (inst_req),
    .inst_end      (inst_end),
    .inst_ack      (inst_ack),
    .inst_dado     (inst_dado),
    .dado_req      (dado_req),
    .dado_we       (dado_we),
    .dado_end      (dado_end),
    .dado_wdata    (dado_wdata),
    .dado_ack      (dado_ack),
    .dado_rdata    (dado_rdata),
    .endereco      (endereco),
    .dado_escrita  (dado_escrita),
    .uc_escrita_mem(uc_escrita_mem),
    .uc_leitura_mem(uc_leitura_mem),
    .instrucao     (instrucao),
    .ocupado       (ocupado)
  );

  always #5 clock = ~clock;

  // Memory model: 0x10 holds 0xDEADBEEF, every other word is addr*0x01010101+0x1000
  assign instrucao = (endereco == 32'h10) ? 32'hDEADBEEF : (endereco * 32'h01010101 + 32'h1000);

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } acc_t;
  typedef struct { logic port; logic [31:0] data; } rsp_t;  // port 1 = data

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   rise_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   scnt = 0;
  logic prev_any = 1'b0;
  acc_t ea;
  rsp_t er;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: access starts, strobe width, ack contents
  always @(negedge clock) begin
    if (uc_escrita_mem && uc_leitura_mem) chk("strobes_exclusive", 1, 0);
    if ((uc_escrita_mem || uc_leitura_mem) && !prev_any) begin
      rise_q.push_back(cyc);
      last_rise = cyc;
      if (acc_q.size() == 0) begin
        chk("unexpected_access", endereco, 32'hFFFF_FFFF);
      end else begin
        ea = acc_q.pop_front();
        chk("acc_addr", endereco, ea.addr);
        chk("acc_we", uc_escrita_mem, ea.we);
        if (ea.we) chk("acc_wdata", dado_escrita, ea.wdata);
      end
    end
    if (uc_escrita_mem || uc_leitura_mem) begin
      scnt++;
    end else begin
      if (prev_any && reset_n) chk("strobe_cycles", scnt, LAT_MEM);
      scnt = 0;
    end
    prev_any = uc_escrita_mem || uc_leitura_mem;
    if (inst_ack || dado_ack) begin
      if (inst_ack && dado_ack) chk("acks_exclusive", 1, 0);
      chk("ack_latency", cyc - last_rise, LAT_MEM);
      if (rsp_q.size() == 0) begin
        chk("unexpected_ack", {inst_ack, dado_ack}, 0);
      end else begin
        er = rsp_q.pop_front();
        chk("ack_port", dado_ack, er.port);
        chk("ack_data", dado_ack ? dado_rdata : inst_dado, er.data);
      end
    end
  end

  // Fetch requester: holds req until ack, returns on the ack negedge
  task automatic inst_txn(input logic [31:0] a);
    bit got = 0;
    inst_req = 1'b1;
    inst_end = a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (inst_ack) begin got = 1; break; end
    end
    if (!got) chk("inst_ack_timeout", 0, 1);
  endtask

  // Data requester: holds req until ack, returns on the ack negedge
  task automatic dado_txn(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bit got = 0;
    dado_req   = 1'b1;
    dado_end   = a;
    dado_we    = we;
    dado_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dado_ack) begin got = 1; break; end
    end
    if (!got) chk("dado_ack_timeout", 0, 1);
  endtask

  task automatic push_acc(input logic [31:0] a, input logic we, input logic [31:0] wd);
    acc_t t;
    t.addr = a; t.we = we; t.wdata = wd;
    acc_q.push_back(t);
  endtask

  task automatic push_rsp(input logic p, input logic [31:0] d);
    rsp_t t;
    t.port = p; t.data = d;
    rsp_q.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; inst_req = 1'b1; inst_end = 32'h1;
    dado_req = 1'b1; dado_we = 1'b0; dado_end = 32'h2; dado_wdata = '0;

    // Contention served right after reset release
`ifdef ROUND_ROBIN_EN
    push_acc(32'h1, 0, 0); push_acc(32'h2, 0, 0);
    push_rsp(0, 32'h01011101); push_rsp(1, 32'h02021202);
`else
    push_acc(32'h2, 0, 0); push_acc(32'h1, 0, 0);
    push_rsp(1, 32'h02021202); push_rsp(0, 32'h01011101);
`endif
    repeat (3) begin
      @(negedge clock);
      chk("reset_ctrl", {inst_ack, dado_ack, uc_escrita_mem, uc_leitura_mem, ocupado}, 0);
      chk("reset_rdata", {inst_dado, dado_rdata}, 0);
      chk("reset_mem", {endereco, dado_escrita}, 0);
    end
    reset_n = 1'b1;
    rise_q.delete();
    @(negedge clock);
    chk("first_grant", {ocupado, uc_leitura_mem, uc_escrita_mem}, 3'b110);
    fork
      begin inst_txn(32'h1); inst_req = 1'b0; end
      begin dado_txn(32'h2, 0, 0); dado_req = 1'b0; end
    join
    chk("contention_accesses", rise_q.size(), 2);
    if (rise_q.size() >= 2) chk("contention_spacing", rise_q[1] - rise_q[0], LAT_MEM + 2);

    // Fetch from 0x10
    push_acc(32'h10, 0, 0); push_rsp(0, 32'hDEADBEEF);
    @(negedge clock);
    inst_txn(32'h10); inst_req = 1'b0;

    // Write 20 to 0x4; load register must keep its last read value
    push_acc(32'h4, 1, 32'd20); push_rsp(1, 32'h02021202);
    @(negedge clock);
    dado_txn(32'h4, 1, 32'd20); dado_req = 1'b0; dado_we = 1'b0;
    repeat (2) @(negedge clock);
    chk("rdata_after_write", dado_rdata, 32'h02021202);
    chk("inst_dado_hold", inst_dado, 32'hDEADBEEF);
    chk("idle_after_write", {ocupado, uc_escrita_mem, uc_leitura_mem}, 0);

    // Reset during second access cycle of a read at 0x8, then reissue
    push_acc(32'h8, 0, 0); push_acc(32'h8, 0, 0); push_rsp(1, 32'h08081808);
    fork
      begin dado_txn(32'h8, 0, 0); dado_req = 1'b0; end
      begin
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          if (uc_leitura_mem) begin seen = 1; break; end
        end
        if (!seen) chk("midreset_no_access", 0, 1);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midreset_ctrl", {inst_ack, dado_ack, uc_escrita_mem, uc_leitura_mem, ocupado}, 0);
        chk("midreset_rdata", {inst_dado, dado_rdata}, 0);
        @(negedge clock);
        reset_n = 1'b1;
      end
    join

    // Both ports re-requesting continuously
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
`ifdef ROUND_ROBIN_EN
    push_acc(32'h20, 0, 0); push_acc(32'h30, 0, 0); push_acc(32'h21, 0, 0); push_acc(32'h31, 0, 0);
    push_rsp(0, 32'h20203020); push_rsp(1, 32'h30304030);
    push_rsp(0, 32'h21213121); push_rsp(1, 32'h31314131);
`else
    push_acc(32'h30, 0, 0); push_acc(32'h31, 0, 0); push_acc(32'h20, 0, 0); push_acc(32'h21, 0, 0);
    push_rsp(1, 32'h30304030); push_rsp(1, 32'h31314131);
    push_rsp(0, 32'h20203020); push_rsp(0, 32'h21213121);
`endif
    fork
      begin inst_txn(32'h20); inst_txn(32'h21); inst_req = 1'b0; end
      begin dado_txn(32'h30, 0, 0); dado_txn(32'h31, 0, 0); dado_req = 1'b0; end
    join

    repeat (4) @(negedge clock);
    chk("acc_queue_empty", acc_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    chk("final_idle", {ocupado, uc_escrita_mem, uc_leitura_mem, inst_ack, dado_ack}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Controller/arbiter sharing the single-port `memoria` block between the instruction-fetch port and the data load/store port.
- Serialises requests and drives `endereco`, `dado_escrita`, `uc_escrita_mem` and `uc_leitura_mem` from registers.
- Holds each strobe for LAT_MEM cycles, captures the read word and returns it to the winning requester with a one-cycle ack.
- Guarantees read and write strobes are never asserted together.

Parameters:
- LARGURA_END, 32, address width.
- LARGURA_DADO, 32, data width.
- LAT_MEM, 2, cycles a strobe is held before read data is captured (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- inst_req  in  1  fetch request; held until inst_ack.
- inst_end  in  LARGURA_END  fetch address.
- inst_ack  out  1  one-cycle completion pulse, fetch port.
- inst_dado  out  LARGURA_DADO  fetched word.
- dado_req  in  1  data request; held until dado_ack.
- dado_we  in  1  1 = write, 0 = read.
- dado_end  in  LARGURA_END  data address.
- dado_wdata  in  LARGURA_DADO  write data.
- dado_ack  out  1  one-cycle completion pulse, data port.
- dado_rdata  out  LARGURA_DADO  loaded word.
- endereco  out  LARGURA_END  memory address.
- dado_escrita  out  LARGURA_DADO  memory write data.
- uc_escrita_mem  out  1  memory write strobe.
- uc_leitura_mem  out  1  memory read strobe.
- instrucao  in  LARGURA_DADO  memory read data.
- ocupado  out  1  high while a transaction is in flight.

Behaviour:
- One clock domain: clock. reset_n is synchronous and active-low.
- Reset values:
  - All outputs 0; state OCIOSO; wait counter 0.
  - Last-grant register = DADO, so inst wins the first tie when ROUND_ROBIN_EN is defined.
- OCIOSO:
  - If no request is pending, stay.
  - Otherwise, at edge E0, select a winner and latch address, write data, we and grant.
  - Load counter with LAT_MEM-1, set ocupado=1, go to ACESSO.
  - Fetch is always a read: inst_ack never accompanies a write.
- ACESSO:
  - Drive endereco and dado_escrita from the latch.
  - uc_escrita_mem = we; uc_leitura_mem = !we. Exactly one strobe is high.
  - Strobes are high from E0 through edge E0+LAT_MEM, i.e. exactly LAT_MEM cycles.
  - Counter decrements each edge. At the edge where counter==0:
    - read: capture instrucao into inst_dado or dado_rdata (per grant);
    - deassert both strobes;
    - go to RESPOSTA.
- RESPOSTA:
  - The granted port's ack is high for exactly one cycle (E0+LAT_MEM to E0+LAT_MEM+1).
  - At E0+LAT_MEM+1: ack drops, ocupado=0, return to OCIOSO.
- Latency and throughput:
  - req sampled at E0 → ack visible after E0+LAT_MEM.
  - Minimum period is LAT_MEM+2 cycles per transaction.
- Read-data outputs:
  - inst_dado and dado_rdata hold their last value until overwritten by a read of their own port.
  - Writes leave dado_rdata unchanged.
- Back-to-back: if req is still high when back in OCIOSO, it is treated as a new transaction. Requesters drop req on the edge after ack to avoid repetition.
- Request changes: changes to inputs of the granted port during ACESSO/RESPOSTA are ignored (latched copy is used). A non-granted request waits.
- Contention (both req high in OCIOSO), default: fixed priority to the data port.
- Reset asserted mid-transaction:
  - Abort at that edge; strobes and ack go to 0.
  - Captured data is cleared; no ack is issued.
  - Requesters reissue after release.
- Address wrap: none; the address passes through unchanged at full width.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined: on contention, the port not granted last wins. Last-grant updates on every grant. With both reqs held high continuously, grants alternate INST, DADO, INST, ... starting with INST after reset.
- Undefined: fixed data-port priority. A continuously asserted dado_req starves inst_req. Last-grant register is unused.

Test Plan (LAT_MEM=2):
- Reset: reset_n=0 for 3 cycles with both reqs high → all outputs 0, no strobes, no ack. After release, first grant begins at the next edge.
- Fetch: inst_req=1, inst_end=0x10, instrucao=0xDEADBEEF → uc_leitura_mem=1 and endereco=0x10 for 2 cycles; inst_ack pulses 1 cycle after E0+2; inst_dado=0xDEADBEEF.
- Write: dado_req=1, dado_we=1, dado_end=0x4, dado_wdata=20 → uc_escrita_mem=1 and dado_escrita=20 for 2 cycles, uc_leitura_mem=0; dado_ack pulses once; dado_rdata unchanged.
- Contention, macro undefined: both reqs rise together, inst_end=0x1, dado_end=0x2 (read) → endereco=0x2 served first, then 0x1. Transactions are 4 cycles apart; strobes never both 1.
- Contention, ROUND_ROBIN_EN defined: both reqs held high, each port re-requesting immediately after its ack → grant order INST, DADO, INST, DADO.
- Mid-access reset: reset_n=0 during second ACESSO cycle of a read at 0x8 → both strobes 0 at that edge, no ack, dado_rdata=0. After release, the reissued request completes normally.
